ring_step_controller: RTL and testbench

Sequencer for a one-hot ring register of WIDTH bits.
- Accepts a start command carrying seed, direction and step count.
- Rotates the ring exactly that many steps, honouring a pause input, then pulses Done.
- Guards ring integrity: non-one-hot seeds are replaced by a legal pattern and flagged.
- Sits between a control FSM/testbench and downstream logic consuming one-hot phase enables.

---
 rtl/ring_pkg.sv | 22 ++
 rtl/ring_shift_reg.sv | 37 +++
 rtl/ring_step_controller.sv | 98 +++++++++
 tb/tb_ring_step_controller.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for the one-hot ring step controller: FSM states,
// direction codes, ring reset pattern and a one-hot test helper.
package ring_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Widest ring supported; narrower rings zero-extend into helpers
    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] RING_RST = 64'd1;

    function automatic logic is_onehot(input logic [MAX_W-1:0] v);
        return (v != '0) && ((v & (v - 64'd1)) == '0);
    endfunction

endpackage

// File: rtl/ring_shift_reg.sv
// WIDTH-bit ring register: synchronous load or one-position rotate.
// Load has priority over rotate; reset restores the single-bit pattern.
module ring_shift_reg
    import ring_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_rot_en,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_q
);

    localparam logic [WIDTH-1:0] W_RST = RING_RST[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_rot;

    // DIR_DOWN moves the hot bit toward bit 0, wrapping bit 0 to the MSB
    assign w_rot = (i_dir == DIR_UP) ? {r_q[WIDTH-2:0], r_q[WIDTH-1]}
                                     : {r_q[0], r_q[WIDTH-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_q <= W_RST;
        else if (i_load)
            r_q <= i_load_val;
        else if (i_rot_en)
            r_q <= w_rot;
    end

    assign o_q = r_q;

endmodule

// File: rtl/ring_step_controller.sv
// Sequencer that loads a one-hot ring, rotates it a commanded number of
// steps (pausable), then pulses Done. Illegal seeds are replaced and flagged.
module ring_step_controller
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Dir,
    input  logic [CNT_W-1:0] Steps,
    input  logic [WIDTH-1:0] Seed,
    input  logic             Pause,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done,
    output logic             Error
);

    localparam logic [WIDTH-1:0] W_RST = RING_RST[WIDTH-1:0];

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_err;

    logic             w_accept;
    logic             w_rot_en;
    logic             w_seed_ok;
    logic [WIDTH-1:0] w_load_val;

    assign w_seed_ok  = is_onehot(MAX_W'(Seed));
    assign w_load_val = w_seed_ok ? Seed : W_RST;

    always_ff @(posedge Clk) begin
        if (Reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (Start) w_next = (Steps != '0) ? RUN : DONE;
            RUN:  if (!Pause && r_cnt == CNT_W'(1)) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_rot_en = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (r_state)
            IDLE: w_accept = Start;
            RUN: begin
                Busy     = 1'b1;
                w_rot_en = !Pause;
            end
            DONE: Done = 1'b1;
            default: ;
        endcase
    end

    // Counter guards against zero so it can never wrap below 0
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt <= '0;
            r_dir <= DIR_DOWN;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= Steps;
            r_dir <= Dir;
            r_err <= !w_seed_ok;
        end else if (w_rot_en && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    ring_shift_reg #(.WIDTH(WIDTH)) u_ring (
        .i_clk      (Clk),
        .i_rst      (Reset),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_rot_en   (w_rot_en),
        .i_dir      (r_dir),
        .o_q        (Q)
    );

    assign Error = r_err;

endmodule

// File: tb/tb_ring_step_controller.sv
// Directed bench for ring_step_controller (WIDTH=4): each step advances one
// clock and checks Q/Busy/Done/Error against hand-computed values.
module tb_ring_step_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Dir = 1'b0;
    logic [7:0] Steps = '0;
    logic [3:0] Seed = '0;
    logic       Pause = 1'b0;
    logic [3:0] Q;
    logic       Busy;
    logic       Done;
    logic       Error;

    int n_assert = 0;
    int n_fail   = 0;

    ring_step_controller #(.WIDTH(4), .CNT_W(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Dir   (Dir),
        .Steps (Steps),
        .Seed  (Seed),
        .Pause (Pause),
        .Q     (Q),
        .Busy  (Busy),
        .Done  (Done),
        .Error (Error)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1ns after the edge, check all outputs
    task automatic step(input string tag, input logic [3:0] eq, input logic eb,
                        input logic ed, input logic ee);
        @(posedge Clk);
        #1;
        chk({tag, ".Q"},     Q,            eq);
        chk({tag, ".Busy"},  {3'b0, Busy}, {3'b0, eb});
        chk({tag, ".Done"},  {3'b0, Done}, {3'b0, ed});
        chk({tag, ".Error"}, {3'b0, Error},{3'b0, ee});
    endtask

    task automatic cmd(input logic [3:0] seed, input logic dir, input logic [7:0] steps);
        Start = 1'b1;
        Seed  = seed;
        Dir   = dir;
        Steps = steps;
    endtask

    initial begin
        // 1: reset, then idle
        step("rst0", 4'b0001, 0, 0, 0);
        step("rst1", 4'b0001, 0, 0, 0);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) step("idle", 4'b0001, 0, 0, 0);

        // 2: seed 0001, down, 3 steps
        cmd(4'b0001, 1'b0, 8'd3);
        step("t2.load", 4'b0001, 1, 0, 0);
        Start = 1'b0;
        step("t2.r1", 4'b1000, 1, 0, 0);
        step("t2.r2", 4'b0100, 1, 0, 0);
        step("t2.r3", 4'b0010, 0, 1, 0);
        step("t2.idle", 4'b0010, 0, 0, 0);

        // 3: seed 0100, up, 5 steps, paused in RUN cycles 2-3
        cmd(4'b0100, 1'b1, 8'd5);
        step("t3.load", 4'b0100, 1, 0, 0);
        Start = 1'b0;
        step("t3.r1", 4'b1000, 1, 0, 0);
        Pause = 1'b1;
        step("t3.p1", 4'b1000, 1, 0, 0);
        step("t3.p2", 4'b1000, 1, 0, 0);
        Pause = 1'b0;
        step("t3.r2", 4'b0001, 1, 0, 0);
        step("t3.r3", 4'b0010, 1, 0, 0);
        step("t3.r4", 4'b0100, 1, 0, 0);
        step("t3.r5", 4'b1000, 0, 1, 0);
        step("t3.idle", 4'b1000, 0, 0, 0);

        // 4: illegal seed 0110 -> 0001 + Error, then legal seed clears it
        cmd(4'b0110, 1'b0, 8'd2);
        step("t4.load", 4'b0001, 1, 0, 1);
        Start = 1'b0;
        step("t4.r1", 4'b1000, 1, 0, 1);
        step("t4.r2", 4'b0100, 0, 1, 1);
        step("t4.idle", 4'b0100, 0, 0, 1);
        cmd(4'b0010, 1'b0, 8'd1);
        step("t4b.load", 4'b0010, 1, 0, 0);
        Start = 1'b0;
        step("t4b.r1", 4'b0001, 0, 1, 0);
        step("t4b.idle", 4'b0001, 0, 0, 0);

        // 5: Steps=0, then Start ignored in DONE and in RUN
        cmd(4'b1000, 1'b0, 8'd0);
        step("t5.zero", 4'b1000, 0, 1, 0);
        cmd(4'b0001, 1'b1, 8'd5);
        step("t5.ignD", 4'b1000, 0, 0, 0);
        cmd(4'b0001, 1'b0, 8'd2);
        step("t5b.load", 4'b0001, 1, 0, 0);
        cmd(4'b0010, 1'b1, 8'd9);
        step("t5b.r1", 4'b1000, 1, 0, 0);
        step("t5b.r2", 4'b0100, 0, 1, 0);
        step("t5b.idle", 4'b0100, 0, 0, 0);
        Start = 1'b0;
        step("t5b.hold", 4'b0100, 0, 0, 0);

        // 6: all-zero seed, reset after 4 rotations, then Start+Pause together
        cmd(4'b0000, 1'b1, 8'd10);
        step("t6.load", 4'b0001, 1, 0, 1);
        Start = 1'b0;
        step("t6.r1", 4'b0010, 1, 0, 1);
        step("t6.r2", 4'b0100, 1, 0, 1);
        step("t6.r3", 4'b1000, 1, 0, 1);
        step("t6.r4", 4'b0001, 1, 0, 1);
        Reset = 1'b1;
        step("t6.rst", 4'b0001, 0, 0, 0);
        Reset = 1'b0;
        step("t6.post", 4'b0001, 0, 0, 0);
        cmd(4'b0010, 1'b0, 8'd1);
        Pause = 1'b1;
        step("t6b.load", 4'b0010, 1, 0, 0);
        Start = 1'b0;
        step("t6b.p", 4'b0010, 1, 0, 0);
        Pause = 1'b0;
        step("t6b.r1", 4'b0001, 0, 1, 0);
        step("t6b.idle", 4'b0001, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
